alu_issue_ctrl: RTL and testbench

- Front end that drives the 64-bit ALU's operation select (4-bit ALU_Select encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass data2, 1100 NOR).
- Accepts 32-bit LEGv8 instruction words over a valid/ready handshake and decodes each into ALU_Select, register addresses and an extended immediate.
- Issues decoded ops through a 2-entry output buffer with its own valid/ready handshake, so instruction fetch and execute stall independently.

---
 rtl/alu_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// LEGv8 instruction decode front end for the 64-bit ALU.
// Decoded ops are issued through a 2-entry FIFO so fetch and execute stall independently.
module alu_issue_ctrl #(
   parameter int n = 63
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         instr_valid,
   input  logic [31:0]  instr,
   output logic         instr_ready,
   output logic         alu_valid,
   input  logic         alu_ready,
   output logic [3:0]   ALU_Select,
   output logic         alu_src_imm,
   output logic [n:0]   imm,
   output logic [4:0]   rd,
   output logic [4:0]   rn,
   output logic [4:0]   rm,
   output logic         illegal,
   output logic [7:0]   illegal_cnt
);

   typedef struct packed {
      logic [3:0] sel;
      logic       src_imm;
      logic [n:0] imm;
      logic [4:0] rd;
      logic [4:0] rn;
      logic [4:0] rm;
   } entry_t;

   entry_t     dec_entry;
   logic       dec_legal;
   entry_t     fifo_q [2];
   logic       head_ptr;
   logic       tail_ptr;
   logic [1:0] count;
   logic       accept;
   logic       push;
   logic       pop;

   // Decode is purely combinational on the offered word; first matching opcode wins.
   always_comb begin
      dec_legal         = 1'b0;
      dec_entry.sel     = 4'b0000;
      dec_entry.src_imm = 1'b0;
      dec_entry.imm     = '0;
      dec_entry.rd      = instr[4:0];
      dec_entry.rn      = instr[9:5];
      dec_entry.rm      = 5'd0;
      if (instr[31:21] == 11'b10001011000) begin
         dec_legal     = 1'b1;
         dec_entry.sel = 4'b0010;
         dec_entry.rm  = instr[20:16];
      end else if (instr[31:21] == 11'b11001011000) begin
         dec_legal     = 1'b1;
         dec_entry.sel = 4'b0110;
         dec_entry.rm  = instr[20:16];
      end else if (instr[31:21] == 11'b10001010000) begin
         dec_legal     = 1'b1;
         dec_entry.sel = 4'b0000;
         dec_entry.rm  = instr[20:16];
      end else if (instr[31:21] == 11'b10101010000) begin
         dec_legal     = 1'b1;
         dec_entry.sel = 4'b0001;
         dec_entry.rm  = instr[20:16];
      end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
         dec_legal         = 1'b1;
         dec_entry.sel     = 4'b0010;
         dec_entry.src_imm = 1'b1;
         dec_entry.imm     = {{(n-8){instr[20]}}, instr[20:12]};
         // STUR carries the store data register in the Rt slot
         dec_entry.rm      = instr[22] ? 5'd0 : instr[4:0];
      end else if (instr[31:22] == 10'b1001000100) begin
         dec_legal         = 1'b1;
         dec_entry.sel     = 4'b0010;
         dec_entry.src_imm = 1'b1;
         dec_entry.imm     = {{(n-11){1'b0}}, instr[21:10]};
      end else if (instr[31:22] == 10'b1101000100) begin
         dec_legal         = 1'b1;
         dec_entry.sel     = 4'b0110;
         dec_entry.src_imm = 1'b1;
         dec_entry.imm     = {{(n-11){1'b0}}, instr[21:10]};
      end else if (instr[31:24] == 8'b10110100) begin
         dec_legal     = 1'b1;
         dec_entry.sel = 4'b0111;
         dec_entry.rm  = instr[4:0];
      end
   end

   assign instr_ready = (count != 2'd2);
   assign alu_valid   = (count != 2'd0);
   assign accept      = instr_valid & instr_ready;
   assign push        = accept & dec_legal & ~flush;
   assign pop         = alu_valid & alu_ready & ~flush;

   // Flush wins over push/pop; illegal words are consumed but never stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         head_ptr    <= 1'b0;
         tail_ptr    <= 1'b0;
         count       <= 2'd0;
         illegal     <= 1'b0;
         illegal_cnt <= 8'd0;
      end else if (flush) begin
         head_ptr <= 1'b0;
         tail_ptr <= 1'b0;
         count    <= 2'd0;
         illegal  <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[tail_ptr] <= dec_entry;
            tail_ptr         <= ~tail_ptr;
         end
         if (pop) begin
            head_ptr <= ~head_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         illegal <= accept & ~dec_legal;
         if (accept && !dec_legal && illegal_cnt != 8'hFF) begin
            illegal_cnt <= illegal_cnt + 8'd1;
         end
      end
   end

   assign ALU_Select  = fifo_q[head_ptr].sel;
   assign alu_src_imm = fifo_q[head_ptr].src_imm;
   assign imm         = fifo_q[head_ptr].imm;
   assign rd          = fifo_q[head_ptr].rd;
   assign rn          = fifo_q[head_ptr].rn;
   assign rm          = fifo_q[head_ptr].rm;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: decode vector table, directed
// handshake/flush/reset sequences and randomized traffic against a queue model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  ALU_Select;
   logic        alu_src_imm;
   logic [63:0] imm;
   logic [4:0]  rd;
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int checkCount = 0;
   int errorCount = 0;

   alu_issue_ctrl #(.n(63)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .ALU_Select(ALU_Select), .alu_src_imm(alu_src_imm), .imm(imm),
      .rd(rd), .rn(rn), .rm(rm),
      .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        legal;
      logic [3:0]  sel;
      logic        src;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rn;
      logic [4:0]  rm;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] word;
      exp_t        exp;
   } vec_t;

   exp_t modelQ[$];
   logic modelIllegal = 1'b0;
   int   modelCnt = 0;

   // Reference decode written from the instruction-class table.
   function automatic exp_t refDecode(input logic [31:0] w);
      exp_t e;
      logic signed [8:0] off9;
      longint offExt;
      e = '0;
      e.rd = w[4:0];
      e.rn = w[9:5];
      off9 = w[20:12];
      offExt = off9;
      if (w[31:21] == 11'h458)      begin e.legal = 1; e.sel = 4'd2; e.rm = w[20:16]; end
      else if (w[31:21] == 11'h658) begin e.legal = 1; e.sel = 4'd6; e.rm = w[20:16]; end
      else if (w[31:21] == 11'h450) begin e.legal = 1; e.sel = 4'd0; e.rm = w[20:16]; end
      else if (w[31:21] == 11'h550) begin e.legal = 1; e.sel = 4'd1; e.rm = w[20:16]; end
      else if (w[31:21] == 11'h7C2) begin e.legal = 1; e.sel = 4'd2; e.src = 1; e.imm = offExt; end
      else if (w[31:21] == 11'h7C0) begin e.legal = 1; e.sel = 4'd2; e.src = 1; e.imm = offExt; e.rm = w[4:0]; end
      else if (w[31:22] == 10'h244) begin e.legal = 1; e.sel = 4'd2; e.src = 1; e.imm = 64'(w[21:10]); end
      else if (w[31:22] == 10'h344) begin e.legal = 1; e.sel = 4'd6; e.src = 1; e.imm = 64'(w[21:10]); end
      else if (w[31:24] == 8'hB4)   begin e.legal = 1; e.sel = 4'd7; e.rm = w[4:0]; end
      return e;
   endfunction

   function automatic void modelStep(input logic iv, input logic [31:0] w, input logic ar, input logic fl);
      exp_t d;
      bit acc;
      if (fl) begin
         modelQ.delete();
         modelIllegal = 1'b0;
         return;
      end
      acc = iv && (modelQ.size() < 2);
      if (modelQ.size() > 0 && ar) void'(modelQ.pop_front());
      modelIllegal = 1'b0;
      if (acc) begin
         d = refDecode(w);
         if (d.legal) modelQ.push_back(d);
         else begin
            modelIllegal = 1'b1;
            if (modelCnt < 255) modelCnt++;
         end
      end
   endfunction

   task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      logic [94:0] act;
      logic [94:0] exp;
      exp_t h;
      h = '0;
      if (modelQ.size() > 0) h = modelQ[0];
      exp = {modelQ.size() > 0, modelQ.size() < 2, modelIllegal, 8'(modelCnt),
             (modelQ.size() > 0) ? {h.sel, h.src, h.imm, h.rd, h.rn, h.rm} : 84'd0};
      act = {alu_valid, instr_ready, illegal, illegal_cnt,
             alu_valid ? {ALU_Select, alu_src_imm, imm, rd, rn, rm} : 84'd0};
      checkValue(name, 128'(act), 128'(exp));
   endtask

   task automatic applyStimulus(input string name, input logic iv, input logic [31:0] w,
                                input logic ar, input logic fl);
      instr_valid = iv;
      instr       = w;
      alu_ready   = ar;
      flush       = fl;
      modelStep(iv, w, ar, fl);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 9))
         0: return {11'h458, r[20:0]};
         1: return {11'h658, r[20:0]};
         2: return {11'h450, r[20:0]};
         3: return {11'h550, r[20:0]};
         4: return {11'h7C2, r[20:0]};
         5: return {11'h7C0, r[20:0]};
         6: return {10'h244, r[21:0]};
         7: return {10'h344, r[21:0]};
         8: return {8'hB4, r[23:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[10];
      vecs[0] = '{"add",  32'h8B020023, '{1, 4'd2, 0, 64'd0, 5'd3, 5'd1, 5'd2}};
      vecs[1] = '{"ldur", 32'hF85F80C5, '{1, 4'd2, 1, 64'hFFFFFFFFFFFFFFF8, 5'd5, 5'd6, 5'd0}};
      vecs[2] = '{"subi", 32'hD13FFC21, '{1, 4'd6, 1, 64'h0FFF, 5'd1, 5'd1, 5'd0}};
      vecs[3] = '{"cbz",  32'hB4000007, '{1, 4'd7, 0, 64'd0, 5'd7, 5'd0, 5'd7}};
      vecs[4] = '{"sub",  32'hCB0B0149, '{1, 4'd6, 0, 64'd0, 5'd9, 5'd10, 5'd11}};
      vecs[5] = '{"and",  32'h8A0600A4, '{1, 4'd0, 0, 64'd0, 5'd4, 5'd5, 5'd6}};
      vecs[6] = '{"orr",  32'hAA090107, '{1, 4'd1, 0, 64'd0, 5'd7, 5'd8, 5'd9}};
      vecs[7] = '{"stur", 32'hF80FF062, '{1, 4'd2, 1, 64'h00FF, 5'd2, 5'd3, 5'd2}};
      vecs[8] = '{"addi", 32'h9100056A, '{1, 4'd2, 1, 64'd1, 5'd10, 5'd11, 5'd0}};
      vecs[9] = '{"ones", 32'hFFFFFFFF, '{0, 4'd0, 0, 64'd0, 5'd0, 5'd0, 5'd0}};

      rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0; alu_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("reset_ctrl", 128'({alu_valid, instr_ready, illegal, illegal_cnt}), 128'({3'b010, 8'd0}));
      checkValue("reset_fields", 128'({ALU_Select, alu_src_imm, imm, rd, rn, rm}), 128'd0);
      rst = 1'b0;

      // Illegal word followed immediately by a legal CBZ.
      applyStimulus("ill_zero", 1, 32'h00000000, 1, 0);
      checkValue("ill_pulse", 128'({illegal, illegal_cnt, alu_valid}), 128'({1'b1, 8'd1, 1'b0}));
      applyStimulus("cbz_after_ill", 1, 32'hB4000007, 1, 0);
      checkValue("cbz_issue", 128'({illegal, alu_valid, ALU_Select, rm}), 128'({1'b0, 1'b1, 4'd7, 5'd7}));
      applyStimulus("cbz_drain", 0, 0, 1, 0);
      checkValue("cbz_gone", 128'(alu_valid), 128'(0));

      // Decode table: each word into an empty buffer, observed one cycle later.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].name, 1, vecs[i].word, 1, 0);
         if (vecs[i].exp.legal)
            checkValue({"vec_", vecs[i].name},
               128'({alu_valid, ALU_Select, alu_src_imm, imm, rd, rn, rm}),
               128'({1'b1, vecs[i].exp.sel, vecs[i].exp.src, vecs[i].exp.imm,
                     vecs[i].exp.rd, vecs[i].exp.rn, vecs[i].exp.rm}));
         else
            checkValue({"vec_", vecs[i].name}, 128'({alu_valid, illegal}), 128'({1'b0, 1'b1}));
         applyStimulus("vec_drain", 0, 0, 1, 0);
      end

      // Backpressure: SUB, AND fill the buffer; ORR waits and issues last.
      applyStimulus("bp_sub", 1, 32'hCB0B0149, 0, 0);
      applyStimulus("bp_and", 1, 32'h8A0600A4, 0, 0);
      checkValue("bp_full", 128'({instr_ready, ALU_Select, rd}), 128'({1'b0, 4'd6, 5'd9}));
      applyStimulus("bp_orr_blocked", 1, 32'hAA090107, 0, 0);
      checkValue("bp_hold", 128'({alu_valid, ALU_Select, rd, rn, rm}), 128'({1'b1, 4'd6, 5'd9, 5'd10, 5'd11}));
      applyStimulus("bp_issue_sub", 1, 32'hAA090107, 1, 0);
      checkValue("bp_head_and", 128'({alu_valid, ALU_Select, rd}), 128'({1'b1, 4'd0, 5'd4}));
      applyStimulus("bp_issue_and", 1, 32'hAA090107, 1, 0);
      checkValue("bp_head_orr", 128'({alu_valid, ALU_Select, rd}), 128'({1'b1, 4'd1, 5'd7}));
      applyStimulus("bp_issue_orr", 0, 0, 1, 0);
      checkValue("bp_empty", 128'(alu_valid), 128'(0));

      // Saturating illegal counter.
      for (int i = 0; i < 300; i++) applyStimulus("ill_burst", 1, 32'hFFFFFFFF, 1, 0);
      checkValue("ill_sat", 128'(illegal_cnt), 128'(255));
      applyStimulus("ill_idle", 0, 0, 1, 0);

      // Flush with two entries buffered and a concurrent push.
      applyStimulus("fl_fill0", 1, 32'h8B020023, 0, 0);
      applyStimulus("fl_fill1", 1, 32'h9100056A, 0, 0);
      applyStimulus("fl_flush", 1, 32'hD13FFC21, 0, 1);
      checkValue("fl_cleared", 128'({alu_valid, instr_ready}), 128'({1'b0, 1'b1}));
      for (int i = 0; i < 3; i++) applyStimulus("fl_idle", 0, 0, 1, 0);
      applyStimulus("fl_fill2", 1, 32'h8B020023, 0, 0);
      applyStimulus("fl_illegal", 1, 32'hFFFFFFFF, 0, 1);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 500; i++)
         applyStimulus("rand", $urandom_range(0, 3) != 0, randInstr(),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

      // Asynchronous reset mid-cycle with two entries buffered.
      applyStimulus("ar_illegal", 1, 32'hFFFFFFFF, 0, 1);
      applyStimulus("ar_illegal2", 1, 32'hFFFFFFFF, 0, 0);
      applyStimulus("ar_fill0", 1, 32'h8B020023, 0, 0);
      applyStimulus("ar_fill1", 1, 32'hCB0B0149, 0, 0);
      instr_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checkValue("ar_immediate", 128'({alu_valid, instr_ready, illegal_cnt}), 128'({1'b0, 1'b1, 8'd0}));
      modelQ.delete();
      modelIllegal = 1'b0;
      modelCnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus("ar_after", 1, 32'h8B020023, 1, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
